// File: rtl/rf_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write ports
// (W0 wins on same-address collisions), optional write bypass and a load-pending scoreboard.

module rf_mp_rd #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic                        reset_n,
  input  logic [AW-1:0]               raddr,
  input  logic [NREGS-1:0][XLEN-1:0]  rf,
  input  logic [NREGS-1:0]            pending,
  input  logic                        w0_ok,
  input  logic [AW-1:0]               w0_addr,
  input  logic [XLEN-1:0]             w0_data,
  input  logic                        w1_en,
  input  logic                        w1_ok,
  input  logic [AW-1:0]               w1_addr,
  input  logic [XLEN-1:0]             w1_data,
  output logic [XLEN-1:0]             rdata,
  output logic                        rbusy
);
  logic [XLEN-1:0] stored;
  logic            busy;

  // Out-of-range addresses match no entry and fall through to zero / not busy.
  always_comb begin
    stored = '0;
    busy   = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (raddr == AW'(r)) begin
        stored = rf[r];
        busy   = pending[r];
      end
    end
    rdata = stored;
    if (BYPASS != 0) begin
      if (w0_ok && w0_addr == raddr)      rdata = w0_data;
      else if (w1_ok && w1_addr == raddr) rdata = w1_data;
    end
    rbusy = busy & ~((BYPASS != 0) && w1_en && (w1_addr == raddr));
    if (!reset_n) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end
endmodule

module rf_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   w0_en,
  input  logic [AW-1:0]          w0_addr,
  input  logic [XLEN-1:0]        w0_data,
  input  logic                   w1_en,
  input  logic [AW-1:0]          w1_addr,
  input  logic [XLEN-1:0]        w1_data,
  input  logic [NRD*AW-1:0]      raddr,
  output logic [NRD*XLEN-1:0]    rdata,
  output logic [NRD-1:0]         rbusy,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_addr,
  output logic [NREGS-1:0]       pending,
  output logic                   wr_conflict,
  output logic [NREGS*XLEN-1:0]  regs
);
  logic [NREGS-1:0][XLEN-1:0] rf;
  logic w0_ok, w1_ok, sb_ok;

  assign w0_ok = w0_en  && (w0_addr != '0) && (int'(w0_addr) < NREGS);
  assign w1_ok = w1_en  && (w1_addr != '0) && (int'(w1_addr) < NREGS);
  assign sb_ok = sb_set && (sb_addr != '0) && (int'(sb_addr) < NREGS);
  assign regs  = rf;

  // W0 is applied after W1 so it wins a same-address collision; a new load's set
  // overrides the clear from the load it replaces.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf          <= '0;
      pending     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (w1_ok && w1_addr == AW'(r)) begin
          rf[r]      <= w1_data;
          pending[r] <= 1'b0;
        end
        if (w0_ok && w0_addr == AW'(r)) rf[r] <= w0_data;
        if (sb_ok && sb_addr == AW'(r)) pending[r] <= 1'b1;
      end
      wr_conflict <= w0_ok && w1_ok && (w0_addr == w1_addr);
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    rf_mp_rd #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(BYPASS)) u_rd (
      .reset_n (reset_n),
      .raddr   (raddr[i*AW +: AW]),
      .rf      (rf),
      .pending (pending),
      .w0_ok   (w0_ok),
      .w0_addr (w0_addr),
      .w0_data (w0_data),
      .w1_en   (w1_en),
      .w1_ok   (w1_ok),
      .w1_addr (w1_addr),
      .w1_data (w1_data),
      .rdata   (rdata[i*XLEN +: XLEN]),
      .rbusy   (rbusy[i])
    );
  end
endmodule

// File: tb/tb_rf_mp.sv
// Bench for rf_mp: bypassing and non-bypassing instances share one stimulus stream,
// checked by directed scenarios and a randomized run against an array-based model.

module tb_rf_mp;
  localparam int XLEN = 32, NREGS = 32, AW = 6, NRD = 2;

  logic clock, reset_n;
  logic w0_en, w1_en, sb_set;
  logic [AW-1:0] w0_addr, w1_addr, sb_addr;
  logic [XLEN-1:0] w0_data, w1_data;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*XLEN-1:0] rdata_b, rdata_n;
  logic [NRD-1:0] rbusy_b, rbusy_n;
  logic [NREGS-1:0] pend_b, pend_n;
  logic conf_b, conf_n;
  logic [NREGS*XLEN-1:0] regs_b, regs_n;

  int checks = 0, failures = 0;

  logic [XLEN-1:0] m_rf [NREGS];
  bit   [NREGS-1:0] m_pend;
  bit               m_conf;

  rf_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .BYPASS(1)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .sb_set(sb_set), .sb_addr(sb_addr), .pending(pend_b),
    .wr_conflict(conf_b), .regs(regs_b));

  rf_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .BYPASS(0)) dut_n (
    .clock(clock), .reset_n(reset_n),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .sb_set(sb_set), .sb_addr(sb_addr), .pending(pend_n),
    .wr_conflict(conf_n), .regs(regs_n));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic drive(input logic e0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                       input logic e1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                       input logic s, input logic [AW-1:0] sa,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    w0_en = e0; w0_addr = a0; w0_data = d0;
    w1_en = e1; w1_addr = a1; w1_data = d1;
    sb_set = s; sb_addr = sa;
    raddr = {r1, r0};
  endtask

  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic bit vld(input logic [AW-1:0] a);
    return (a != 0) && (int'(a) < NREGS);
  endfunction

  // Read value seen by a port this cycle, from the stored model plus the write rules.
  function automatic logic [XLEN-1:0] exp_rd(input bit bp, input logic [AW-1:0] a);
    if (!vld(a)) return '0;
    if (bp && w0_en && w0_addr == a) return w0_data;
    if (bp && w1_en && w1_addr == a) return w1_data;
    return m_rf[int'(a)];
  endfunction

  function automatic logic exp_busy(input bit bp, input logic [AW-1:0] a);
    if (!vld(a)) return 1'b0;
    return m_pend[int'(a)] && !(bp && w1_en && w1_addr == a);
  endfunction

  task automatic model_commit();
    bit v0, v1, vs;
    v0 = w0_en && vld(w0_addr);
    v1 = w1_en && vld(w1_addr);
    vs = sb_set && vld(sb_addr);
    if (v1) begin m_rf[int'(w1_addr)] = w1_data; m_pend[int'(w1_addr)] = 1'b0; end
    if (v0) m_rf[int'(w0_addr)] = w0_data;
    if (vs) m_pend[int'(sb_addr)] = 1'b1;
    m_conf = v0 && v1 && (w0_addr == w1_addr);
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) m_rf[r] = '0;
    m_pend = '0;
    m_conf = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(0, 0);
    #2;
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1, 6'(3), $urandom, 1, 6'(4), $urandom, 1, 6'(4), 6'(3), 6'(4));
    #2;
    checks++;
    if (rdata_b !== '0 || rdata_n !== '0) begin
      failures++;
      $display("FAIL reset_rdata: got b=%h n=%h want 0", rdata_b, rdata_n);
    end
    checks++;
    if (rbusy_b !== '0 || rbusy_n !== '0) begin
      failures++;
      $display("FAIL reset_rbusy: got b=%b n=%b want 0", rbusy_b, rbusy_n);
    end
    tick();
    checks++;
    if (regs_b !== '0 || regs_n !== '0) begin
      failures++;
      $display("FAIL reset_regs: regs nonzero while reset held");
    end
    checks++;
    if (pend_b !== '0 || pend_n !== '0 || conf_b !== 1'b0 || conf_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: pend=%h/%h conf=%b/%b want 0", pend_b, pend_n, conf_b, conf_n);
    end
    idle(0, 0);
    reset_n = 1'b1;
  endtask

  task automatic test_dual_write();
    drive(1, 6'(5), 32'hDEADBEEF, 1, 6'(6), 32'h12345678, 0, 0, 0, 0);
    tick();
    idle(6'(5), 6'(6));
    #2;
    checks++;
    if (rdata_b !== {32'h12345678, 32'hDEADBEEF} || rdata_n !== {32'h12345678, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL dual_write: got b=%h n=%h want 12345678deadbeef", rdata_b, rdata_n);
    end
    checks++;
    if (conf_b !== 1'b0) begin
      failures++;
      $display("FAIL dual_write_conflict: got %b want 0", conf_b);
    end
    tick();
  endtask

  task automatic test_conflict();
    drive(1, 6'(7), 32'hAAAA0000, 1, 6'(7), 32'h5555FFFF, 0, 0, 0, 0);
    tick();
    idle(6'(7), 0);
    #2;
    checks++;
    if (rdata_b[31:0] !== 32'hAAAA0000 || rdata_n[31:0] !== 32'hAAAA0000) begin
      failures++;
      $display("FAIL conflict_data: got b=%h n=%h want aaaa0000", rdata_b[31:0], rdata_n[31:0]);
    end
    checks++;
    if (conf_b !== 1'b1 || conf_n !== 1'b1) begin
      failures++;
      $display("FAIL conflict_flag: got %b/%b want 1", conf_b, conf_n);
    end
    tick();
    checks++;
    if (conf_b !== 1'b0 || conf_n !== 1'b0) begin
      failures++;
      $display("FAIL conflict_one_cycle: got %b/%b want 0", conf_b, conf_n);
    end
  endtask

  task automatic test_x0_oob();
    logic [NREGS*XLEN-1:0] want;
    want = '0;
    want[5*XLEN +: XLEN] = 32'hDEADBEEF;
    want[6*XLEN +: XLEN] = 32'h12345678;
    want[7*XLEN +: XLEN] = 32'hAAAA0000;
    drive(1, 6'(0), 32'hFFFFFFFF, 1, 6'(40), 32'hCAFEF00D, 1, 6'(40), 6'(0), 6'(40));
    #2;
    checks++;
    if (rdata_b !== '0 || rdata_n !== '0) begin
      failures++;
      $display("FAIL x0_oob_bypass: got b=%h n=%h want 0", rdata_b, rdata_n);
    end
    tick();
    idle(6'(0), 6'(40));
    #2;
    checks++;
    if (rdata_b !== '0 || rdata_n !== '0 || rbusy_b !== '0) begin
      failures++;
      $display("FAIL x0_oob_read: got b=%h n=%h busy=%b want 0", rdata_b, rdata_n, rbusy_b);
    end
    checks++;
    if (regs_b !== want || regs_n !== want || pend_b !== '0) begin
      failures++;
      $display("FAIL x0_oob_regs: x0=%h x7=%h pend=%h want x0=0 x7=aaaa0000 pend=0",
               regs_b[31:0], regs_b[7*XLEN +: XLEN], pend_b);
    end
    tick();
  endtask

  task automatic test_bypass();
    drive(1, 6'(9), 32'h11, 0, 0, 0, 1, 6'(9), 0, 0);
    tick();
    drive(0, 0, 0, 1, 6'(9), 32'h42, 0, 0, 6'(9), 0);
    #2;
    checks++;
    if (rdata_b[31:0] !== 32'h42 || rbusy_b[0] !== 1'b0) begin
      failures++;
      $display("FAIL bypass_on: got data=%h busy=%b want 42/0", rdata_b[31:0], rbusy_b[0]);
    end
    checks++;
    if (rdata_n[31:0] !== 32'h11 || rbusy_n[0] !== 1'b1) begin
      failures++;
      $display("FAIL bypass_off: got data=%h busy=%b want 11/1", rdata_n[31:0], rbusy_n[0]);
    end
    tick();
    idle(6'(9), 0);
    #2;
    checks++;
    if (rdata_n[31:0] !== 32'h42 || pend_b[9] !== 1'b0 || pend_n[9] !== 1'b0) begin
      failures++;
      $display("FAIL bypass_commit: got data=%h pend=%b/%b want 42/0/0", rdata_n[31:0], pend_b[9], pend_n[9]);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    drive(0, 0, 0, 0, 0, 0, 1, 6'(10), 0, 0);
    tick();
    idle(6'(10), 6'(11));
    #2;
    checks++;
    if (pend_b[10] !== 1'b1 || rbusy_b !== 2'b01 || rbusy_n !== 2'b01) begin
      failures++;
      $display("FAIL sb_set: got pend=%b busy=%b/%b want 1/01/01", pend_b[10], rbusy_b, rbusy_n);
    end
    drive(0, 0, 0, 1, 6'(10), 32'h77, 1, 6'(10), 0, 0);
    tick();
    checks++;
    if (pend_b[10] !== 1'b1 || pend_n[10] !== 1'b1) begin
      failures++;
      $display("FAIL sb_set_wins: got %b/%b want 1", pend_b[10], pend_n[10]);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 6'(11), 0, 0);
    tick();
    drive(1, 6'(11), 32'h99, 0, 0, 0, 1, 6'(11), 0, 0);
    tick();
    checks++;
    if (pend_b[11] !== 1'b1) begin
      failures++;
      $display("FAIL sb_w0_noclear: got %b want 1", pend_b[11]);
    end
    drive(0, 0, 0, 1, 6'(10), 32'h78, 0, 0, 0, 0);
    tick();
    checks++;
    if (pend_b[10] !== 1'b0 || pend_b[11] !== 1'b1) begin
      failures++;
      $display("FAIL sb_w1_clear: got p10=%b p11=%b want 0/1", pend_b[10], pend_b[11]);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a0, a1, sa, r0, r1;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      a0 = 6'($urandom_range(0, 35));
      a1 = ($urandom_range(0, 5) == 0) ? a0 : 6'($urandom_range(0, 35));
      sa = ($urandom_range(0, 3) == 0) ? a1 : 6'($urandom_range(0, 35));
      r0 = ($urandom_range(0, 2) == 0) ? a1 : 6'($urandom_range(0, 35));
      r1 = ($urandom_range(0, 2) == 0) ? a0 : 6'($urandom_range(0, 35));
      drive(1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom,
            1'($urandom), sa, r0, r1);
      #2;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (rdata_b[p*XLEN +: XLEN] !== exp_rd(1, raddr[p*AW +: AW]) ||
            rbusy_b[p] !== exp_busy(1, raddr[p*AW +: AW])) begin
          failures++;
          $display("FAIL rand_read_b n=%0d port=%0d: got %h/%b want %h/%b", n, p,
                   rdata_b[p*XLEN +: XLEN], rbusy_b[p],
                   exp_rd(1, raddr[p*AW +: AW]), exp_busy(1, raddr[p*AW +: AW]));
        end
        checks++;
        if (rdata_n[p*XLEN +: XLEN] !== exp_rd(0, raddr[p*AW +: AW]) ||
            rbusy_n[p] !== exp_busy(0, raddr[p*AW +: AW])) begin
          failures++;
          $display("FAIL rand_read_n n=%0d port=%0d: got %h/%b want %h/%b", n, p,
                   rdata_n[p*XLEN +: XLEN], rbusy_n[p],
                   exp_rd(0, raddr[p*AW +: AW]), exp_busy(0, raddr[p*AW +: AW]));
        end
      end
      tick();
      model_commit();
      checks++;
      if (pend_b !== m_pend || pend_n !== m_pend || conf_b !== m_conf || conf_n !== m_conf) begin
        failures++;
        $display("FAIL rand_state n=%0d: pend=%h/%h conf=%b/%b want %h/%b", n,
                 pend_b, pend_n, conf_b, conf_n, m_pend, m_conf);
      end
      for (int r = 0; r < NREGS; r++) begin
        checks++;
        if (regs_b[r*XLEN +: XLEN] !== m_rf[r] || regs_n[r*XLEN +: XLEN] !== m_rf[r]) begin
          failures++;
          $display("FAIL rand_reg n=%0d x%0d: got %h/%h want %h", n, r,
                   regs_b[r*XLEN +: XLEN], regs_n[r*XLEN +: XLEN], m_rf[r]);
        end
      end
    end
    // Asynchronous reset mid-operation wipes everything immediately.
    drive(1, 6'(3), 32'h5, 1, 6'(4), 32'h6, 1, 6'(3), 6'(3), 6'(4));
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (regs_b !== '0 || pend_b !== '0 || conf_b !== 1'b0 || rdata_b !== '0) begin
      failures++;
      $display("FAIL midop_reset: pend=%h conf=%b rdata=%h want all 0", pend_b, conf_b, rdata_b);
    end
    reset_n = 1'b1;
    idle(0, 0);
  endtask

  initial begin
    reset_n = 1'b1;
    idle(0, 0);
    #1;
    test_reset();
    tick();
    test_dual_write();
    test_conflict();
    test_x0_oob();
    test_bypass();
    test_scoreboard();
    test_random();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
